shift_rotate_unit: RTL and testbench

Parametrised multi-cycle shift/rotate unit for the CPU datapath ALU. It replaces the single-mode, single-cycle SHL path. It supports five operations (SHL, SHR, SHRA, ROL, ROR) at any WIDTH and shifts STEP bits per clock. The control sequencer drives it with a start/done handshake: operand A comes from the Y path, the amount from the bus operand, and the result is written toward Z.

---
 rtl/shift_rotate_unit_if.sv | 40 ++++
 rtl/shift_rotate_unit.sv | 151 +++++++++++++++
 tb/tb_shift_rotate_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_rotate_unit_if.sv
// Shift/rotate unit request/response bundle.
//   master : control sequencer (drives start/op/a/amt, observes result/status)
//   slave  : shift_rotate_unit
// Signals: start, op[2:0], a[WIDTH], amt[AMT_W] ; result[WIDTH], busy, ready, done
// Optional carry_out is present only when SHIFT_CARRY_EN is defined.
interface shift_rotate_unit_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned AMT_W = $clog2(WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             ready;
    logic             done;
`ifdef SHIFT_CARRY_EN
    logic             carry_out;

    modport master (
        output start, op, a, amt,
        input  result, busy, ready, done, carry_out
    );
    modport slave (
        input  start, op, a, amt,
        output result, busy, ready, done, carry_out
    );
`else
    modport master (
        output start, op, a, amt,
        input  result, busy, ready, done
    );
    modport slave (
        input  start, op, a, amt,
        output result, busy, ready, done
    );
`endif
endinterface

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: SHL, SHR, SHRA, ROL, ROR, up to STEP bits per clock.
// Ports:
//   Clock : rising-edge clock
//   Clear : asynchronous active-low reset
//   bus   : shift_rotate_unit_if.slave (start/op/a/amt in; result/busy/ready/done out)
// Optional feature macro: SHIFT_CARRY_EN adds bus.carry_out (last bit shifted out / wrapped).
// Latency: start accepted at edge E -> done visible after edge E + ceil(amt/STEP) + 1.
module shift_rotate_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic                  Clock,
    input  logic                  Clear,
    shift_rotate_unit_if.slave    bus
);
    localparam int unsigned AMT_W = $clog2(WIDTH);
    // One extra bit so STEP == WIDTH is representable.
    localparam int unsigned KW    = AMT_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [2:0]       op_reg, op_nxt;
    logic [AMT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             busy_nxt, ready_nxt, done_nxt;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] shifted;
    logic             start_op_valid;
`ifdef SHIFT_CARRY_EN
    logic             cwork, cwork_nxt;
    logic             carry_nxt;
    logic             shifted_bit;
`endif

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_nxt  = state;
        work_nxt   = work;
        op_nxt     = op_reg;
        count_nxt  = count;
        result_nxt = bus.result;
        shifted    = work;
`ifdef SHIFT_CARRY_EN
        cwork_nxt   = cwork;
        carry_nxt   = bus.carry_out;
        shifted_bit = 1'b0;
`endif
        start_op_valid = (bus.op <= OP_ROR);

        // Bits moved this cycle: min(STEP, remaining count)
        k = (KW'(count) < KW'(STEP)) ? KW'(count) : KW'(STEP);

        case (op_reg)
            OP_SHL:  shifted = work << k;
            OP_SHR:  shifted = work >> k;
            OP_SHRA: shifted = WIDTH'($signed(work) >>> k);
            OP_ROL:  shifted = (work << k) | (work >> (KW'(WIDTH) - k));
            OP_ROR:  shifted = (work >> k) | (work << (KW'(WIDTH) - k));
            default: shifted = work;
        endcase

`ifdef SHIFT_CARRY_EN
        // Left moves lose/wrap bit WIDTH-k; right moves lose/wrap bit k-1
        case (op_reg)
            OP_SHL, OP_ROL:           shifted_bit = work[AMT_W'(KW'(WIDTH) - k)];
            OP_SHR, OP_SHRA, OP_ROR:  shifted_bit = work[AMT_W'(k - KW'(1))];
            default:                  shifted_bit = 1'b0;
        endcase
`endif

        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    work_nxt  = bus.a;
                    op_nxt    = bus.op;
                    count_nxt = start_op_valid ? bus.amt : '0;
`ifdef SHIFT_CARRY_EN
                    cwork_nxt = 1'b0;
`endif
                    // Zero amount or undefined op complete as a pass-through
                    state_nxt = (start_op_valid && (bus.amt != '0)) ? S_SHIFT : S_DONE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_nxt  = shifted;
                count_nxt = count - AMT_W'(k);
`ifdef SHIFT_CARRY_EN
                cwork_nxt = shifted_bit;
`endif
                if (count_nxt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Status follows the state being entered; done/result publish the finished word
        busy_nxt  = (state_nxt == S_SHIFT);
        ready_nxt = (state_nxt != S_SHIFT);
        done_nxt  = (state == S_DONE);
        if (state == S_DONE) begin
            result_nxt = work;
`ifdef SHIFT_CARRY_EN
            carry_nxt  = cwork;
`endif
        end
    end

    // State, datapath and output registers
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state      <= S_IDLE;
            work       <= '0;
            op_reg     <= '0;
            count      <= '0;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.ready  <= 1'b1;
            bus.done   <= 1'b0;
`ifdef SHIFT_CARRY_EN
            cwork         <= 1'b0;
            bus.carry_out <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            work       <= work_nxt;
            op_reg     <= op_nxt;
            count      <= count_nxt;
            bus.result <= result_nxt;
            bus.busy   <= busy_nxt;
            bus.ready  <= ready_nxt;
            bus.done   <= done_nxt;
`ifdef SHIFT_CARRY_EN
            cwork         <= cwork_nxt;
            bus.carry_out <= carry_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench for shift_rotate_unit (WIDTH=32, STEP=4).
// The stimulus side pushes model expectations; a negedge monitor checks every done pulse.
module tb_shift_rotate_unit;
    localparam int unsigned W    = 32;
    localparam int unsigned STEP = 4;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        int           busy;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;
    int   done_seen = 0;
    exp_t sb[$];

    shift_rotate_unit_if #(.WIDTH(W)) bus ();

    shift_rotate_unit #(.WIDTH(W), .STEP(STEP)) dut (
        .Clock (clk),
        .Clear (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-amount reference: each result bit picked directly from the operand
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input int amt);
        exp_t e;
        e.res   = a;
        e.carry = 1'b0;
        e.busy  = 0;
        e.due   = 0;
        if (op > 3'd4 || amt == 0) return e;
        for (int i = 0; i < int'(W); i++) begin
            case (op)
                3'd0: e.res[i] = (i >= amt) ? a[i - amt] : 1'b0;
                3'd1: e.res[i] = (i + amt < int'(W)) ? a[i + amt] : 1'b0;
                3'd2: e.res[i] = (i + amt < int'(W)) ? a[i + amt] : a[W-1];
                3'd3: e.res[i] = a[(i - amt + int'(W)) % int'(W)];
                default: e.res[i] = a[(i + amt) % int'(W)];
            endcase
        end
        e.carry = (op == 3'd0 || op == 3'd3) ? a[int'(W) - amt] : a[amt - 1];
        e.busy  = (amt + int'(STEP) - 1) / int'(STEP);
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input int amt);
        exp_t e;
        int   n = 0;
        while (!bus.ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: ready still 0 after %0d cycles", n);
            return;
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.amt   = 5'(amt);
        e = model(op, a, amt);
        // Accept edge is cyc+1; done is visible busy+1 edges later
        e.due = cyc + 1 + e.busy + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.amt   = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: result 0x%0h with empty scoreboard", bus.result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 64'(bus.result), 64'(e.res));
                    check("latency", 64'(cyc), 64'(e.due));
                    check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
`ifdef SHIFT_CARRY_EN
                    check("carry_out", 64'(bus.carry_out), 64'(e.carry));
`endif
                end
                busy_cnt = 0;
            end
            if (bus.busy) busy_cnt++;
        end
    end

    initial begin
        int snap;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.amt   = '0;
        repeat (3) @(negedge clk);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_ready", 64'(bus.ready), 64'd1);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(3'd0, 32'd12, 15);
        issue(3'd2, 32'h8000_0010, 4);
        issue(3'd1, 32'h8000_0010, 4);
        issue(3'd4, 32'h0000_0001, 1);
        issue(3'd3, 32'h8000_0000, 1);
        issue(3'd0, 32'hDEAD_BEEF, 0);
        issue(3'd7, 32'hDEAD_BEEF, 5);
        issue(3'd0, 32'h0000_0001, 31);
        issue(3'd2, 32'h8000_0001, 31);
        drain();

        // Start while shifting is ignored
        issue(3'd0, 32'd1, 20);
        @(negedge clk);
        check("ready_while_busy", 64'(bus.ready), 64'd0);
        check("busy_while_shift", 64'(bus.busy), 64'd1);
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.amt   = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Back-to-back: second start issued as soon as ready returns
        issue(3'd0, 32'd1, 31);
        issue(3'd3, 32'h1234_5678, 9);
        issue(3'd1, 32'hF000_000F, 0);
        issue(3'd4, 32'hA5A5_0003, 2);
        drain();

        // Randomized traffic with random idle gaps
        for (int i = 0; i < 80; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // Asynchronous reset mid-operation discards the operation
        issue(3'd3, 32'hCAFE_F00D, 31);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset_result", 64'(bus.result), 64'd0);
        check("midop_reset_busy", 64'(bus.busy), 64'd0);
        check("midop_reset_done", 64'(bus.done), 64'd0);
        check("midop_reset_ready", 64'(bus.ready), 64'd1);
        sb.delete();
        busy_cnt = 0;
        snap = done_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_reset", 64'(done_seen), 64'(snap));
        check("idle_ready_after_reset", 64'(bus.ready), 64'd1);

        // Unit still works after the reset
        issue(3'd1, 32'h8000_0000, 31);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
